// File: rtl/wb_arb_pkg.sv
// Purpose : shared types and constants for the two-master Wishbone arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

  // Arbiter FSM: idle, or one master owns the slave port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Master indices as stored in last_gnt.
  localparam logic M_INSTR = 1'b0;
  localparam logic M_DATA  = 1'b1;

  // One-hot grant encoding {m1,m0}.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Purpose : bus watchdog; counts granted cycles without ack/err, flags expiry.
// Latency : expire is combinational from the registered count.
// Backpressure: none; the arbiter releases the grant when expire is acted upon.
// Ports   : clk, rst (async, active-high); clr restarts the count; en advances it;
//           expire is high while count == TIMEOUT-1.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturating guard only; the forced release normally stops counting first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Purpose : two-master (m0 instr, m1 data) to one-slave Wishbone classic arbiter,
//           round-robin on ties, grant released on every ack/err, watchdog timeout.
// Latency : grant one edge after request; ack/err/data return combinationally;
//           one idle cycle between transfers.
// Backpressure: a waiting master simply holds cyc/stb until granted.
// Ports   : clk, rst; m0_*/m1_* master side; s_* slave side; gnt_o one-hot
//           {m1,m0}; timeout_o pulses when the watchdog terminates a transfer.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  state_t state, state_nxt;
  logic   last_gnt;
  logic   req0, req1;
  logic   own_cyc;
  logic   wd_expire, wd_fire;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Owner's cyc; zero when idle, so it also gates everything returned to masters.
  // An owner that drops cyc stops seeing a late ack in the same cycle.
  assign own_cyc = ((state == GNT0) & m0_cyc_i) | ((state == GNT1) & m1_cyc_i);

  // A real ack/err in the expiry cycle takes precedence over the timeout.
  assign wd_fire = own_cyc & wd_expire & ~s_ack_i & ~s_err_i;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .en     ((state != IDLE) & ~s_ack_i & ~s_err_i),
    .expire (wd_expire)
  );

  // State register; last_gnt records the master granted on each IDLE exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= M_INSTR;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GNT0) last_gnt <= M_INSTR;
      else if (state == IDLE && state_nxt == GNT1) last_gnt <= M_DATA;
    end
  end

  // Next state: round-robin on ties, release on ack/err/abort/timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = (last_gnt == M_DATA) ? GNT0 : GNT1;
        else if (req0)     state_nxt = GNT0;
        else if (req1)     state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_cyc || s_ack_i || s_err_i || wd_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: slave mux and owner-only ack/err, all zero while idle or in reset.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    gnt_o     = GNT_NONE;
    timeout_o = wd_fire;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i;
        m0_ack_o = own_cyc & s_ack_i;
        m0_err_o = (own_cyc & s_err_i) | wd_fire;
        gnt_o    = GNT_M0;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i;
        m1_ack_o = own_cyc & s_ack_i;
        m1_err_o = (own_cyc & s_err_i) | wd_fire;
        gnt_o    = GNT_M1;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Purpose : self-checking bench for wb_bus_arbiter (TIMEOUT=4).
// Latency : inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_wb_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, s_dat = '0;
  logic        m0_we = 0, m0_cyc = 0, m0_stb = 0, m1_we = 0, m1_cyc = 0, m1_stb = 0;
  logic        s_ack = 0, s_err = 0;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
  logic [1:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner (-1 idle), last granted master, cycles waited.
  int own = -1;
  int lst = 0;
  int waited = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  task automatic check(input string name, input logic [137:0] act, input logic [137:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Spec-level model: evaluates this cycle's outputs, then advances to the next edge.
  task automatic model_check(input string name);
    logic [1:0]  cyc, stb, we, e_ack, e_err, e_gnt;
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [31:0] e_sadr, e_sdat;
    logic        e_we, e_cyc, e_stb, e_to, oc, expire;
    bit          req0, req1;
    cyc = {m1_cyc, m0_cyc}; stb = {m1_stb, m0_stb}; we = {m1_we, m0_we};
    adr[0] = m0_adr; adr[1] = m1_adr; dat[0] = m0_dat; dat[1] = m1_dat;
    e_sadr = '0; e_sdat = '0; e_we = 0; e_cyc = 0; e_stb = 0;
    e_ack = '0; e_err = '0; e_gnt = '0; e_to = 0;
    req0 = m0_cyc && m0_stb;
    req1 = m1_cyc && m1_stb;
    if (rst) begin
      own = -1; lst = 0; waited = 0;
    end else if (own < 0) begin
      if (req0 && req1) own = 1 - lst;
      else if (req0)    own = 0;
      else if (req1)    own = 1;
      if (own >= 0) begin lst = own; waited = 0; end
    end else begin
      oc     = cyc[own];
      expire = oc && (waited == T - 1) && !s_ack && !s_err;
      e_sadr = adr[own]; e_sdat = dat[own]; e_we = we[own];
      e_cyc  = oc; e_stb = oc & stb[own];
      e_ack[own] = oc & s_ack;
      e_err[own] = oc & (s_err | expire);
      e_gnt[own] = 1'b1;
      e_to   = expire;
      if (!oc || s_ack || s_err || expire) own = -1;
      else waited++;
    end
    check({name, "_model"},
          {s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o,
           m1_ack_o, m1_err_o, gnt_o, timeout_o, m0_dat_o, m1_dat_o},
          {e_sadr, e_sdat, e_we, e_cyc, e_stb, e_ack[0], e_err[0],
           e_ack[1], e_err[1], e_gnt, e_to, s_dat, s_dat});
  endtask

  // One cycle: drive on the falling edge, sample shortly after, check vs model.
  task automatic row(input string name, input logic r, input logic c0, input logic c1,
                     input logic [31:0] a1, input logic ack, input logic err,
                     input logic [31:0] sd);
    @(negedge clk);
    rst = r;
    m0_cyc = c0; m0_stb = c0; m0_we = 1'b0; m0_adr = 32'h100; m0_dat = 32'hA0A0_0100;
    m1_cyc = c1; m1_stb = c1; m1_we = 1'b1; m1_adr = a1; m1_dat = 32'hD000_0000 | a1;
    s_ack = ack; s_err = err; s_dat = sd;
    #1 model_check(name);
  endtask

  // ctl = {gnt[1:0], s_cyc, m0_ack, m1_ack, m0_err, m1_err, timeout}
  typedef struct {
    string       name;
    logic        r, c0, c1;
    logic [31:0] a1;
    logic        ack, err;
    logic [31:0] sd;
    logic [7:0]  e_ctl;
    logic [31:0] e_sadr;
  } vec_t;

  function automatic vec_t v(input string n, input logic r, input logic c0, input logic c1,
                             input logic [31:0] a1, input logic ack, input logic err,
                             input logic [31:0] sd, input logic [7:0] ec, input logic [31:0] ea);
    vec_t x;
    x.name = n; x.r = r; x.c0 = c0; x.c1 = c1; x.a1 = a1; x.ack = ack; x.err = err;
    x.sd = sd; x.e_ctl = ec; x.e_sadr = ea;
    return x;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   n;
    localparam logic [7:0] Z = 8'b00_0_00_00_0;
    // Reset in the middle of a GNT1 transfer, then first tie goes to m1.
    tbl.push_back(v("rst_hold",   1, 0, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("rst_req",    0, 0, 1, 32'h400, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("rst_gnt1",   0, 0, 1, 32'h400, 0, 0, 32'h0, 8'b10_1_00_00_0, 32'h400));
    tbl.push_back(v("rst_mid",    1, 0, 1, 32'h400, 1, 0, 32'h1, Z, 32'h0));
    tbl.push_back(v("rst_tie",    0, 1, 1, 32'h400, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("rst_tie_m1", 0, 1, 1, 32'h400, 1, 0, 32'h2, 8'b10_1_01_00_0, 32'h400));
    tbl.push_back(v("rst_done",   0, 0, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));
    // Single master read, ack two cycles after s_cyc rises.
    tbl.push_back(v("rd_req",  0, 1, 0, 32'h0, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("rd_w0",   0, 1, 0, 32'h0, 0, 0, 32'h0, 8'b01_1_00_00_0, 32'h100));
    tbl.push_back(v("rd_w1",   0, 1, 0, 32'h0, 0, 0, 32'h0, 8'b01_1_00_00_0, 32'h100));
    tbl.push_back(v("rd_ack",  0, 1, 0, 32'h0, 1, 0, 32'hDEADBEEF, 8'b01_1_10_00_0, 32'h100));
    tbl.push_back(v("rd_idle", 0, 0, 0, 32'h0, 0, 0, 32'h0, Z, 32'h0));
    // Contention: m0 always requesting, m1 issues three writes.
    tbl.push_back(v("ct_i0",  0, 1, 1, 32'h200, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ct_m1a", 0, 1, 1, 32'h200, 1, 0, 32'h0, 8'b10_1_01_00_0, 32'h200));
    tbl.push_back(v("ct_i1",  0, 1, 1, 32'h204, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ct_m0a", 0, 1, 1, 32'h204, 1, 0, 32'h0, 8'b01_1_10_00_0, 32'h100));
    tbl.push_back(v("ct_i2",  0, 1, 1, 32'h204, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ct_m1b", 0, 1, 1, 32'h204, 1, 0, 32'h0, 8'b10_1_01_00_0, 32'h204));
    tbl.push_back(v("ct_i3",  0, 1, 1, 32'h208, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ct_m0b", 0, 1, 1, 32'h208, 1, 0, 32'h0, 8'b01_1_10_00_0, 32'h100));
    tbl.push_back(v("ct_i4",  0, 1, 1, 32'h208, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ct_m1c", 0, 1, 1, 32'h208, 1, 0, 32'h0, 8'b10_1_01_00_0, 32'h208));
    tbl.push_back(v("ct_i5",  0, 1, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ct_m0c", 0, 1, 0, 32'h0,   1, 0, 32'h0, 8'b01_1_10_00_0, 32'h100));
    tbl.push_back(v("ct_end", 0, 0, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));
    // Watchdog fires in the 4th granted cycle.
    tbl.push_back(v("to_req", 0, 0, 1, 32'h300, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("to_w0",  0, 0, 1, 32'h300, 0, 0, 32'h0, 8'b10_1_00_00_0, 32'h300));
    tbl.push_back(v("to_w1",  0, 0, 1, 32'h300, 0, 0, 32'h0, 8'b10_1_00_00_0, 32'h300));
    tbl.push_back(v("to_w2",  0, 0, 1, 32'h300, 0, 0, 32'h0, 8'b10_1_00_00_0, 32'h300));
    tbl.push_back(v("to_fire",0, 0, 1, 32'h300, 0, 0, 32'h0, 8'b10_1_00_01_1, 32'h300));
    tbl.push_back(v("to_idle",0, 0, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));
    // Ack arriving in the expiry cycle wins.
    tbl.push_back(v("ta_req", 0, 0, 1, 32'h304, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ta_w0",  0, 0, 1, 32'h304, 0, 0, 32'h0, 8'b10_1_00_00_0, 32'h304));
    tbl.push_back(v("ta_w1",  0, 0, 1, 32'h304, 0, 0, 32'h0, 8'b10_1_00_00_0, 32'h304));
    tbl.push_back(v("ta_w2",  0, 0, 1, 32'h304, 0, 0, 32'h0, 8'b10_1_00_00_0, 32'h304));
    tbl.push_back(v("ta_ack", 0, 0, 1, 32'h304, 1, 0, 32'h55, 8'b10_1_01_00_0, 32'h304));
    tbl.push_back(v("ta_idle",0, 0, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));
    // Owner abort; late ack dropped; pending m1 granted next edge.
    tbl.push_back(v("ab_req", 0, 1, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ab_g0",  0, 1, 1, 32'h500, 0, 0, 32'h0, 8'b01_1_00_00_0, 32'h100));
    tbl.push_back(v("ab_drop",0, 0, 1, 32'h500, 1, 0, 32'h0, 8'b01_0_00_00_0, 32'h100));
    tbl.push_back(v("ab_idle",0, 0, 1, 32'h500, 0, 0, 32'h0, Z, 32'h0));
    tbl.push_back(v("ab_m1",  0, 0, 1, 32'h500, 1, 0, 32'h0, 8'b10_1_01_00_0, 32'h500));
    tbl.push_back(v("ab_end", 0, 0, 0, 32'h0,   0, 0, 32'h0, Z, 32'h0));

    foreach (tbl[i]) begin
      row(tbl[i].name, tbl[i].r, tbl[i].c0, tbl[i].c1, tbl[i].a1, tbl[i].ack, tbl[i].err, tbl[i].sd);
      check(tbl[i].name,
            {98'b0, gnt_o, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o, s_adr_o},
            {98'b0, tbl[i].e_ctl, tbl[i].e_sadr});
      if (tbl[i].name == "rd_ack")
        check("rd_data", {106'b0, m0_dat_o}, {106'b0, 32'hDEADBEEF});
    end

    // Hand sequence: ack and err together are both forwarded, grant released.
    row("ae_req", 0, 1, 0, 32'h0, 0, 0, 32'h0);
    row("ae_both", 0, 1, 0, 32'h0, 1, 1, 32'h77);
    check("ae_fwd", {136'b0, m0_ack_o, m0_err_o}, {136'b0, 2'b11});
    row("ae_rel", 0, 0, 0, 32'h0, 0, 0, 32'h0);
    check("ae_gnt", {136'b0, gnt_o}, {136'b0, 2'b00});

    // Hand sequence: bounded wait for an m1 grant, then a slave error.
    n = 0;
    row("bw_req", 0, 0, 1, 32'h600, 0, 0, 32'h0);
    while (gnt_o != 2'b10 && n < 8) begin
      row("bw_wait", 0, 0, 1, 32'h600, 0, 0, 32'h0);
      n++;
    end
    check("bw_gnt", {136'b0, gnt_o}, {136'b0, 2'b10});
    row("bw_err", 0, 0, 1, 32'h600, 0, 1, 32'h0);
    check("bw_errfwd", {136'b0, m1_err_o, timeout_o}, {136'b0, 2'b10});
    row("bw_end", 0, 0, 0, 32'h0, 0, 0, 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 99) == 0);
      m0_cyc = ($urandom_range(0, 3) != 0); m0_stb = ($urandom_range(0, 3) != 0);
      m1_cyc = ($urandom_range(0, 3) != 0); m1_stb = ($urandom_range(0, 3) != 0);
      m0_we  = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = $urandom; m1_adr = $urandom; m0_dat = $urandom; m1_dat = $urandom;
      s_dat  = $urandom;
      s_ack  = ($urandom_range(0, 4) == 0);
      s_err  = ($urandom_range(0, 15) == 0);
      #1 model_check("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
